// File: rtl/vend_pkg.sv
// vend_pkg: coin constants, default amount width and FSM states shared by the vending machine and change dispenser.
package vend_pkg;
   localparam int AW = 7;
   localparam int QV = 25;
   localparam int DV = 10;
   localparam int NV = 5;
   typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
endpackage

// File: rtl/coin_inventory.sv
// coin_inventory: saturating up/down coin counter; a simultaneous inc and dec cancel out.
module coin_inventory #(
   parameter int INV_W = 4,
   parameter int INIT  = 4
) (
   input  logic             clk,
   input  logic             R,
   input  logic             inc,
   input  logic             dec,
   output logic [INV_W-1:0] cnt
);
   logic [INV_W-1:0] r_cnt;
   always_ff @(posedge clk or posedge R) begin
      if (R) r_cnt <= INV_W'(INIT);
      else if (inc && !dec && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
      else if (dec && !inc && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign cnt = r_cnt;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout as one-cycle coin pulses, with per-denomination inventory.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int AW         = vend_pkg::AW,
   parameter int INV_W      = 4,
   parameter int GAP_CYCLES = 1,
   parameter int INIT_Q     = 4,
   parameter int INIT_D     = 4,
   parameter int INIT_N     = 4
) (
   input  logic             clk,
   input  logic             R,
   input  logic             start,
   input  logic [AW-1:0]    amount,
   input  logic             inc_q,
   input  logic             inc_d,
   input  logic             inc_n,
   output logic             Q_o,
   output logic             D_o,
   output logic             N_o,
   output logic             busy,
   output logic             done,
   output logic             short_fall,
   output logic [AW-1:0]    remaining,
   output logic [INV_W-1:0] q_cnt,
   output logic [INV_W-1:0] d_cnt,
   output logic [INV_W-1:0] n_cnt
);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [AW-1:0] QA = AW'(QV);
   localparam logic [AW-1:0] DA = AW'(DV);
   localparam logic [AW-1:0] NA = AW'(NV);
   localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t          r_state, w_next;
   logic [AW-1:0]   r_rem, r_remaining, w_coin;
   logic [GW-1:0]   r_gap;
   logic            r_q, r_d, r_n, r_busy, r_done, r_short;
   logic            w_q, w_d, w_n, w_pick;

   // Greedy pick in priority order; only meaningful while in SELECT.
   assign w_q    = r_state == SELECT && r_rem >= QA && q_cnt != '0;
   assign w_d    = r_state == SELECT && !w_q && r_rem >= DA && d_cnt != '0;
   assign w_n    = r_state == SELECT && !w_q && !w_d && r_rem >= NA && n_cnt != '0;
   assign w_pick = w_q | w_d | w_n;
   assign w_coin = w_q ? QA : w_d ? DA : w_n ? NA : '0;

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    w_next = start ? SELECT : IDLE;
         SELECT:  w_next = w_pick ? PULSE : DONE;
         PULSE:   w_next = (GAP_CYCLES > 0) ? GAP : SELECT;
         GAP:     w_next = (r_gap == '0) ? SELECT : GAP;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         r_state     <= IDLE;
         r_rem       <= '0;
         r_remaining <= '0;
         r_gap       <= '0;
         r_q         <= 1'b0;
         r_d         <= 1'b0;
         r_n         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_short     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_q     <= w_q;
         r_d     <= w_d;
         r_n     <= w_n;
         r_busy  <= w_next != IDLE;
         r_done  <= r_state == SELECT && !w_pick;
         r_gap   <= (r_state == GAP) ? r_gap - 1'b1 : GAP_LOAD;
         if (r_state == IDLE && start) begin
            r_rem       <= amount;
            r_remaining <= '0;
            r_short     <= 1'b0;
         end else if (r_state == SELECT) begin
            r_rem <= r_rem - w_coin;
         end
         if (r_state == SELECT && !w_pick) begin
            r_remaining <= r_rem;
            r_short     <= r_rem != '0;
         end
      end
   end

   coin_inventory #(.INV_W(INV_W), .INIT(INIT_Q)) u_q (.clk(clk), .R(R), .inc(inc_q), .dec(w_q), .cnt(q_cnt));
   coin_inventory #(.INV_W(INV_W), .INIT(INIT_D)) u_d (.clk(clk), .R(R), .inc(inc_d), .dec(w_d), .cnt(d_cnt));
   coin_inventory #(.INV_W(INV_W), .INIT(INIT_N)) u_n (.clk(clk), .R(R), .inc(inc_n), .dec(w_n), .cnt(n_cnt));

   assign Q_o        = r_q;
   assign D_o        = r_d;
   assign N_o        = r_n;
   assign busy       = r_busy;
   assign done       = r_done;
   assign short_fall = r_short;
   assign remaining  = r_remaining;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scenario tasks checking the dispenser against a greedy payout model with inventory tracking.
module tb_change_dispenser;
   localparam int AW    = 7;
   localparam int INV_W = 4;
   localparam int G     = 1;
   localparam int P     = 2 + G;
   localparam int MAXC  = 15;

   logic             clk = 1'b1;
   logic             R = 1'b1, start = 1'b0, inc_q = 1'b0, inc_d = 1'b0, inc_n = 1'b0;
   logic [AW-1:0]    amount = '0;
   logic             Q_o, D_o, N_o, busy, done, short_fall;
   logic [AW-1:0]    remaining;
   logic [INV_W-1:0] q_cnt, d_cnt, n_cnt;

   int n_chk = 0, n_fail = 0;
   int mq = 4, md = 4, mn = 4;

   always #5 clk = ~clk;

   change_dispenser #(.AW(AW), .INV_W(INV_W), .GAP_CYCLES(G), .INIT_Q(4), .INIT_D(4), .INIT_N(4)) dut (
      .clk(clk), .R(R), .start(start), .amount(amount),
      .inc_q(inc_q), .inc_d(inc_d), .inc_n(inc_n),
      .Q_o(Q_o), .D_o(D_o), .N_o(N_o), .busy(busy), .done(done),
      .short_fall(short_fall), .remaining(remaining),
      .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt)
   );

   task automatic check_counts(input string tag);
      n_chk++;
      if (q_cnt !== INV_W'(mq) || d_cnt !== INV_W'(md) || n_cnt !== INV_W'(mn)) begin
         n_fail++;
         $display("FAIL %s counts got %0d/%0d/%0d want %0d/%0d/%0d", tag, q_cnt, d_cnt, n_cnt, mq, md, mn);
      end
   endtask

   task automatic add(input int which, input int n);
      @(negedge clk);
      inc_q = (which == 0);
      inc_d = (which == 1);
      inc_n = (which == 2);
      repeat (n) @(negedge clk);
      inc_q = 1'b0;
      inc_d = 1'b0;
      inc_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (which == 0) mq = (mq < MAXC) ? mq + 1 : MAXC;
         if (which == 1) md = (md < MAXC) ? md + 1 : MAXC;
         if (which == 2) mn = (mn < MAXC) ? mn + 1 : MAXC;
      end
   endtask

   task automatic pay(input int amt, input bit inc_first);
      int exp_c[$];
      int r, idx, coin;
      bit seen;
      r = amt;
      forever begin
         if (r >= 25 && mq > 0) begin exp_c.push_back(25); r -= 25; mq--; end
         else if (r >= 10 && md > 0) begin exp_c.push_back(10); r -= 10; md--; end
         else if (r >= 5 && mn > 0) begin exp_c.push_back(5); r -= 5; mn--; end
         else break;
      end
      if (inc_first) mq = (mq < MAXC) ? mq + 1 : MAXC;
      @(negedge clk);
      start = 1'b1;
      amount = AW'(amt);
      idx = 0;
      seen = 0;
      for (int t = 1; t <= 200 && !seen; t++) begin
         @(negedge clk);
         if (t == 1) begin
            start = 1'b0;
            inc_q = inc_first;
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start amt=%0d got %b want 1", amt, busy); end
         end
         if (t == 2) inc_q = 1'b0;
         if (Q_o | D_o | N_o) begin
            coin = Q_o ? 25 : D_o ? 10 : 5;
            n_chk++;
            if ($countones({Q_o, D_o, N_o}) != 1 || idx >= exp_c.size() || coin != exp_c[idx] || t != 2 + idx * P) begin
               n_fail++;
               $display("FAIL pulse amt=%0d idx=%0d t=%0d got coin %0d (QDN=%b%b%b) want coin %0d at t=%0d",
                        amt, idx, t, coin, Q_o, D_o, N_o, (idx < exp_c.size()) ? exp_c[idx] : 0, 2 + idx * P);
            end
            idx++;
         end
         if (done) begin
            seen = 1;
            n_chk++;
            if (t != 2 + exp_c.size() * P || idx != exp_c.size()) begin
               n_fail++;
               $display("FAIL done_time amt=%0d got t=%0d pulses=%0d want t=%0d pulses=%0d", amt, t, idx, 2 + exp_c.size() * P, exp_c.size());
            end
            n_chk++;
            if (remaining !== AW'(r) || short_fall !== (r != 0)) begin
               n_fail++;
               $display("FAIL result amt=%0d got rem=%0d sf=%b want rem=%0d sf=%b", amt, remaining, short_fall, r, r != 0);
            end
         end
      end
      if (!seen) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout amt=%0d got no done want done", amt);
      end
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after amt=%0d got busy=%b done=%b want 0/0", amt, busy, done); end
      check_counts("after_pay");
   endtask

   task automatic test_reset;
      R = 1'b1;
      #75;
      R = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({Q_o, D_o, N_o, busy, done, short_fall} !== 6'b0 || remaining !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got QDN=%b%b%b busy=%b done=%b sf=%b rem=%0d want all 0",
                  Q_o, D_o, N_o, busy, done, short_fall, remaining);
      end
      check_counts("reset");
   endtask

   task automatic test_basic;
      pay(40, 0);
   endtask

   task automatic test_greedy_short;
      pay(50, 0);
      pay(15, 0);
      add(1, 1);
      pay(5, 0);
      pay(5, 0);
      check_counts("greedy_setup");
      pay(30, 0);
   endtask

   task automatic test_residue;
      add(0, 3);
      add(2, 2);
      pay(7, 0);
      pay(0, 0);
   endtask

   task automatic test_inc_dispense;
      pay(25, 1);
      add(0, 20);
      check_counts("saturate");
   endtask

   task automatic test_random;
      for (int i = 0; i < 12; i++) begin
         add(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
         pay(int'($urandom_range(0, 127)), 0);
      end
   endtask

   task automatic test_reset_midpay;
      bit hit;
      add(0, 3);
      @(negedge clk);
      start = 1'b1;
      amount = AW'(75);
      hit = 0;
      for (int t = 1; t <= 10 && !hit; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (Q_o) hit = 1;
      end
      n_chk++;
      if (!hit) begin n_fail++; $display("FAIL midpay_pulse got no Q_o want Q_o"); end
      R = 1'b1;
      #1;
      n_chk++;
      if (Q_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL midpay_reset got Q=%b busy=%b done=%b want 0/0/0", Q_o, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_chk++;
         if (done !== 1'b0) begin n_fail++; $display("FAIL midpay_no_done got %b want 0", done); end
      end
      R = 1'b0;
      mq = 4;
      md = 4;
      mn = 4;
      @(negedge clk);
      check_counts("midpay_release");
      pay(40, 0);
   endtask

   initial begin
      test_reset;
      test_basic;
      test_greedy_short;
      test_residue;
      test_inc_dispense;
      test_random;
      test_reset_midpay;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
